// File: rtl/scan_display_if.sv
// Bus between the scan_display core and its host: shadowed display inputs in, multiplexed LED drive out.
// The host holds the master modport and the display core holds the slave modport.
interface scan_display_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   en;
  logic                load;
  logic [7:0]          SEG;
  logic [DIGITS-1:0]   AN;
  logic                frame_done;

  modport master (
    output data, dp, en, load,
    input  SEG, AN, frame_done
  );

  modport slave (
    input  data, dp, en, load,
    output SEG, AN, frame_done
  );
endinterface

// File: rtl/scan_display.sv
// Multiplexed 7-segment scanner: DIV clk cycles per digit slot; SEG/AN/frame_done are registered, one cycle behind the index.
// Live inputs are only sampled into shadows at frame boundaries after a load. LEADING_ZERO_BLANK_EN enables leading-zero blanking.
module scan_display #(
  parameter int DIGITS = 8,
  parameter int DIV    = 100000
) (
  input  logic          clk,
  input  logic          rst,
  scan_display_if.slave bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(DIV);

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                pend_q, pend_d;
  logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]   sh_en_q, sh_en_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                fd_q, fd_d;

  logic                tick;
  logic                boundary;
  logic [3:0]          nib;
  logic                dp_cur;
  logic                lit;
`ifdef LEADING_ZERO_BLANK_EN
  logic                zrun;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign tick     = (presc_q == PW'(DIV - 1));
  assign boundary = tick && (idx_q == IW'(DIGITS - 1));

  // A load on the boundary cycle itself captures immediately, as does one left pending.
  always_comb begin
    presc_d   = tick ? '0 : presc_q + PW'(1);
    idx_d     = idx_q;
    pend_d    = pend_q | bus.load;
    sh_data_d = sh_data_q;
    sh_dp_d   = sh_dp_q;
    sh_en_d   = sh_en_q;
    fd_d      = boundary;
    if (tick) begin
      idx_d = boundary ? '0 : idx_q + IW'(1);
    end
    if (boundary) begin
      pend_d = 1'b0;
      if (pend_q || bus.load) begin
        sh_data_d = bus.data;
        sh_dp_d   = bus.dp;
        sh_en_d   = bus.en;
      end
    end
  end

  always_comb begin
    nib    = 4'h0;
    dp_cur = 1'b0;
    lit    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib    = sh_data_q[4*i +: 4];
        dp_cur = sh_dp_q[i];
        lit    = sh_en_q[i];
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; zrun stays set while every digit so far is zero.
    zrun = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zrun = zrun && (sh_data_q[4*i +: 4] == 4'h0);
      if ((idx_q == IW'(i)) && (i != 0) && zrun && !sh_dp_q[i]) begin
        lit = 1'b0;
      end
    end
`endif
    an_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (lit && (idx_q == IW'(i))) begin
        an_d[i] = 1'b0;
      end
    end
    seg_d = lit ? {~dp_cur, hex7(nib)} : 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      sh_data_q <= '0;
      sh_dp_q   <= '0;
      sh_en_q   <= '0;
      seg_q     <= 8'hFF;
      an_q      <= '1;
      fd_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      sh_data_q <= sh_data_d;
      sh_dp_q   <= sh_dp_d;
      sh_en_q   <= sh_en_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      fd_q      <= fd_d;
    end
  end

  assign bus.SEG        = seg_q;
  assign bus.AN         = an_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_scan_display.sv
// Randomized and directed bench for scan_display; the reference derives slot, digit and frame from an absolute cycle count.
module tb_scan_display;
  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scan_display_if #(.DIGITS(DIGITS)) bif ();
  scan_display #(.DIGITS(DIGITS), .DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bif));

  logic [6:0] HEX [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int n_cmp = 0;
  int n_bad = 0;

  int         t;
  bit         m_pend;
  logic [3:0] m_data [DIGITS];
  bit         m_dp   [DIGITS];
  bit         m_en   [DIGITS];
  logic [7:0]        exp_seg;
  logic [DIGITS-1:0] exp_an;
  logic              exp_fd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic bit shown(input int i);
    bit s;
`ifdef LEADING_ZERO_BLANK_EN
    bit allz;
`endif
    s = m_en[i];
`ifdef LEADING_ZERO_BLANK_EN
    if (i != 0 && !m_dp[i]) begin
      allz = 1'b1;
      for (int j = i; j < DIGITS; j++) if (m_data[j] != 4'h0) allz = 1'b0;
      if (allz) s = 1'b0;
    end
`endif
    return s;
  endfunction

  // Cycle t after reset: slot = t / DIV, digit = slot % DIGITS; last cycle of each frame is the boundary.
  task automatic model_edge();
    int cur;
    bit bnd;
    if (rst) begin
      t = 0;
      m_pend = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        m_data[i] = 4'h0; m_dp[i] = 1'b0; m_en[i] = 1'b0;
      end
      exp_seg = 8'hFF; exp_an = '1; exp_fd = 1'b0;
    end else begin
      cur = (t / DIV) % DIGITS;
      exp_seg = 8'hFF; exp_an = '1;
      if (shown(cur)) begin
        exp_an[cur] = 1'b0;
        exp_seg = {~m_dp[cur], HEX[m_data[cur]]};
      end
      bnd = (t % FRAME) == FRAME - 1;
      exp_fd = bnd;
      if (bnd) begin
        if (m_pend || bif.load) begin
          for (int i = 0; i < DIGITS; i++) begin
            m_data[i] = bif.data[4*i +: 4]; m_dp[i] = bif.dp[i]; m_en[i] = bif.en[i];
          end
        end
        m_pend = 1'b0;
      end else if (bif.load) begin
        m_pend = 1'b1;
      end
      t++;
    end
  endtask

  task automatic check();
    chk("SEG", {24'h0, bif.SEG}, {24'h0, exp_seg});
    chk("AN", {28'h0, bif.AN}, {28'h0, exp_an});
    chk("frame_done", {31'h0, bif.frame_done}, {31'h0, exp_fd});
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic wait_fd();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3 * FRAME && !ok; i++) begin
      cyc();
      if (bif.frame_done) ok = 1'b1;
    end
    chk("frame_done_wait", {31'h0, ok}, 32'h1);
  endtask

  logic [DIGITS-1:0] an_lit  [DIGITS] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0]        seg_lit [DIGITS] = '{8'hC0, 8'h12, 8'h88, 8'hB0};

  initial begin
    int pulses, last_k, lit_cnt;
    bif.data = '0; bif.dp = '0; bif.en = '0; bif.load = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) cyc();
    chk("reset_AN", {28'h0, bif.AN}, 32'hF);
    chk("reset_SEG", {24'h0, bif.SEG}, 32'hFF);
    rst = 1'b0;

    // No load: dark forever, frame_done every FRAME cycles
    pulses = 0; last_k = 0;
    for (int k = 1; k <= 3 * FRAME; k++) begin
      cyc();
      if (bif.frame_done) begin pulses++; last_k = k; end
    end
    chk("fd_pulses", pulses, 3);
    chk("fd_last_cycle", last_k, 3 * FRAME);
    chk("idle_AN", {28'h0, bif.AN}, 32'hF);

    // Captured frame walks digits with the decoded values
    bif.data = 16'h3A50; bif.en = 4'hF; bif.dp = 4'b0010; bif.load = 1'b1;
    cyc();
    bif.load = 1'b0;
    wait_fd();
    for (int k = 1; k <= FRAME; k++) begin
      cyc();
      if ((k - 1) % DIV == 0) begin
        chk("walk_AN", {28'h0, bif.AN}, {28'h0, an_lit[(k-1)/DIV]});
        chk("walk_SEG", {24'h0, bif.SEG}, {24'h0, seg_lit[(k-1)/DIV]});
      end
    end

    // Live changes without load are ignored; a load takes the boundary-cycle value
    bif.data = 16'hFFFF;
    repeat (FRAME + 5) cyc();
    bif.load = 1'b1; cyc(); bif.load = 1'b0;
    cyc();
    bif.load = 1'b1; cyc(); bif.load = 1'b0;
    bif.data = 16'h1234;
    wait_fd();
    cyc();
    chk("reload_SEG", {24'h0, bif.SEG}, 32'h99);
    chk("reload_AN", {28'h0, bif.AN}, 32'hE);

    // Only enabled digits drive AN low
    bif.en = 4'b0101; bif.load = 1'b1; cyc(); bif.load = 1'b0;
    wait_fd();
    lit_cnt = 0;
    for (int k = 0; k < FRAME; k++) begin
      cyc();
      if (bif.AN != 4'hF) lit_cnt++;
    end
    chk("en_lit_cycles", lit_cnt, 2 * DIV);

    // Reset in slot 2 with a load pending discards it
    wait_fd();
    bif.en = 4'hF; bif.data = 16'h8888; bif.load = 1'b1; cyc(); bif.load = 1'b0;
    repeat (2 * DIV) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_AN", {28'h0, bif.AN}, 32'hF);
    chk("rst_SEG", {24'h0, bif.SEG}, 32'hFF);
    lit_cnt = 0;
    for (int k = 0; k < 2 * FRAME + 4; k++) begin
      cyc();
      if (bif.AN != 4'hF) lit_cnt++;
    end
    chk("rst_no_capture", lit_cnt, 0);

    // Randomized traffic, including sporadic resets and repeated loads
    for (int k = 0; k < 800; k++) begin
      bif.data = 16'($urandom);
      bif.dp   = 4'($urandom);
      bif.en   = 4'($urandom);
      bif.load = ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0; bif.load = 1'b0;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/scan_display.md
SCAN_DISPLAY -- requirements
Module: scan_display

Interface
REQ-001 The block SHALL have parameter DIGITS, default 8, giving the number of multiplexed digits (legal range 1..16).
REQ-002 The block SHALL have parameter DIV, default 100000, giving the clk cycles per digit slot (legal range >= 2).
REQ-003 The block SHALL have port clk  input  1  system clock, the only clock.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port data  input  4*DIGITS  hex nibble per digit; digit i = data[4i+3:4i].
REQ-006 The block SHALL have port dp  input  DIGITS  decimal point request per digit (1 = lit).
REQ-007 The block SHALL have port en  input  DIGITS  digit enable (0 = digit dark).
REQ-008 The block SHALL have port load  input  1  single-cycle request to capture data/dp/en.
REQ-009 The block SHALL have port SEG  output  8  active-low segments; SEG[0]=CA ... SEG[6]=CG, SEG[7]=DP.
REQ-010 The block SHALL have port AN  output  DIGITS  active-low digit selects; AN[i] drives digit i.
REQ-011 The block SHALL have port frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 The prescaler SHALL count 0..DIV-1 and wrap; tick = (prescaler == DIV-1).
REQ-013 The digit index SHALL increment on tick, wrapping DIGITS-1 -> 0; that wrap is the frame boundary.
REQ-014 SEG and AN SHALL be registered, reflecting the new index on the clk edge after the index changes (1-cycle latency).
REQ-015 Exactly one AN bit SHALL be low at a time, the current index, and only if the shadow en bit is 1; otherwise AN is all ones and SEG = 8'hFF.
REQ-016 Hex decode (SEG[6:0], CG..CA, active-low) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-017 SEG[7] SHALL be the inverted shadow dp bit of the current digit.
REQ-018 Display SHALL use only shadow copies of data/dp/en; live inputs never reach SEG/AN directly.
REQ-019 A load pulse SHALL set a pending flag; shadows capture live inputs at the next frame boundary and the flag clears.
REQ-020 load coincident with the frame-boundary tick SHALL capture the inputs on that same tick.
REQ-021 Additional load pulses while pending SHALL be absorbed; the capture takes input values at the boundary cycle.
REQ-022 frame_done SHALL pulse high for one cycle on each frame-boundary tick, regardless of load.
REQ-023 With DIGITS=1 the index SHALL stay 0 and every tick is a frame boundary.

Reset
REQ-024 While rst=1 on a clk edge: prescaler=0, index=0, pending=0, shadow data/dp/en=0.
REQ-025 Outputs after reset SHALL be AN=all ones, SEG=8'hFF, frame_done=0.
REQ-026 rst asserted mid-slot or mid-pending SHALL abort the slot and discard the pending load; scanning restarts at digit 0 with a full DIV-cycle slot.

Configuration
REQ-027 With macro LEADING_ZERO_BLANK_EN defined, digits from DIGITS-1 downward whose shadow value is 0 SHALL be dark (AN high, SEG=8'hFF) until the first nonzero digit; digit 0 always shows; a lit dp on a blanked digit keeps that digit shown.
REQ-028 Without LEADING_ZERO_BLANK_EN, every enabled digit SHALL display its value including leading zeros.

Verification (DIGITS=4, DIV=4 unless stated)
REQ-029 Reset, no load -> AN=4'b1111, SEG=8'hFF indefinitely; frame_done pulses every 16 cycles.
REQ-030 data=16'h3A50, en=4'hF, dp=4'b0010, load -> after next boundary AN walks 1110,1101,1011,0111 every 4 cycles; SEG = 8'hC0, 8'h12, 8'h88, 8'hB0 in that order (SEG[7]=0 only on digit 1).
REQ-031 Change data mid-frame without load -> SEG unchanged; load mid-frame then change data before boundary -> boundary-cycle value displayed from next frame.
REQ-032 en=4'b0101 -> AN low only in slots 0 and 2; slots 1 and 3 all-ones with SEG=8'hFF.
REQ-033 LEADING_ZERO_BLANK_EN defined, data=16'h0040, en=4'hF -> digits 3,2 dark, digits 1 (4) and 0 (0) lit; data=16'h0000 -> only digit 0 lit showing 0.
REQ-034 rst pulsed in slot 2 with pending load -> next cycle AN=1111, SEG=8'hFF, shadows zero, no capture at following boundary.
